// File: rtl/addsub_arb_ctrl.sv
// Two-requester round-robin adder/subtractor that resolves one 4-bit ripple slice per cycle.
// Valid/ready: a request transfers in a cycle where reqN_valid and reqN_ready are both high; a result transfers where rsp_valid and rsp_ready are both high.
module addsub_arb_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_of,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [NW-1:0] LAST_NIB = NW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [NW-1:0]    nib_q;
    logic             carry_q;
    logic             id_q;
    logic             last_q;
    logic             cout_q;
    logic             of_q;

    logic             grant0;
    logic             grant1;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       low_d;
    logic [1:0]       top_d;
    logic [3:0]       sum_nib_d;
    logic             carry_d;
    logic             of_d;

    // Requester 0 wins a tie when requester 1 was granted last, and vice versa.
    assign grant0 = (state_q == IDLE) && !rst && req0_valid && (!req1_valid || last_q);
    assign grant1 = (state_q == IDLE) && !rst && req1_valid && (!req0_valid || !last_q);

    // Slice split at bit 3 so the carry into the nibble MSB is visible for overflow.
    always_comb begin
        a_nib     = a_q[{nib_q, 2'b00} +: 4];
        b_nib     = b_q[{nib_q, 2'b00} +: 4];
        low_d     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};
        top_d     = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, low_d[3]};
        sum_nib_d = {top_d[0], low_d[2:0]};
        carry_d   = top_d[1];
        of_d      = low_d[3] ^ top_d[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            nib_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q     <= grant1 ? req1_a : req0_a;
                        b_q     <= grant1 ? (req1_b ^ {WIDTH{req1_mode}})
                                          : (req0_b ^ {WIDTH{req0_mode}});
                        carry_q <= grant1 ? req1_mode : req0_mode;
                        id_q    <= grant1;
                        last_q  <= grant1;
                        nib_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    sum_q[{nib_q, 2'b00} +: 4] <= sum_nib_d;
                    carry_q <= carry_d;
                    nib_q   <= nib_q + 1'b1;
                    if (nib_q == LAST_NIB) begin
                        cout_q  <= carry_d;
                        of_q    <= of_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = id_q;
    assign rsp_sum    = sum_q;
    assign rsp_cout   = cout_q;
    assign rsp_of     = of_q;

endmodule

// File: tb/tb_addsub_arb_ctrl.sv
// Randomized and directed bench for addsub_arb_ctrl, checked against a cycle-level reference model.
module tb_addsub_arb_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] ra[2];
    logic [W-1:0] rb[2];
    logic         rm[2];
    logic         rv[2];
    logic         req0_ready;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_of;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    addsub_arb_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (rv[0]),
        .req0_ready (req0_ready),
        .req0_a     (ra[0]),
        .req0_b     (rb[0]),
        .req0_mode  (rm[0]),
        .req1_valid (rv[1]),
        .req1_ready (req1_ready),
        .req1_a     (ra[1]),
        .req1_b     (rb[1]),
        .req1_mode  (rm[1]),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_of     (rsp_of),
        .busy       (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Result from the arithmetic definition: {id, overflow, carry, sum}.
    function automatic logic [W+2:0] ref_result(input logic id, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic mode);
        longint ua, ub, sa, sb, iu, is;
        logic co, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        if (mode) begin
            iu = ua - ub;
            co = (ua >= ub);
            is = sa - sb;
        end else begin
            iu = ua + ub;
            co = (iu >= (longint'(1) << W));
            is = sa + sb;
        end
        ov = (is > (longint'(1) << (W-1)) - 1) || (is < -(longint'(1) << (W-1)));
        return {id, ov, co, W'(iu)};
    endfunction

    // reference model state
    logic [W+2:0] exp_q[$];
    int           m_wait  = 0;
    bit           m_done  = 0;
    bit           m_last  = 1;
    bit           m_fresh = 1;
    bit           mon_en  = 1;
    bit           e_busy, e_g0, e_g1;
    logic [W+2:0] e_rsp;

    // scoreboard: compare at negedge, then advance the model for the coming posedge
    always @(negedge clk) begin
        if (mon_en) begin
            e_busy = (m_wait > 0) || m_done;
            e_g0 = !rst && !e_busy && rv[0] && (!rv[1] || m_last);
            e_g1 = !rst && !e_busy && rv[1] && (!rv[0] || !m_last);
            check_eq("busy", busy, e_busy);
            check_eq("req0_ready", req0_ready, e_g0);
            check_eq("req1_ready", req1_ready, e_g1);
            check_eq("rsp_valid", rsp_valid, m_done);
            if (m_done) begin
                check_eq("exp_q_nonempty", exp_q.size() > 0, 1);
                e_rsp = (exp_q.size() > 0) ? exp_q[0] : '0;
                check_eq("rsp_sum", rsp_sum, e_rsp[W-1:0]);
                check_eq("rsp_cout", rsp_cout, e_rsp[W]);
                check_eq("rsp_of", rsp_of, e_rsp[W+1]);
                check_eq("rsp_id", rsp_id, e_rsp[W+2]);
            end else if (m_fresh && !rst) begin
                check_eq("reset_sum", rsp_sum, 0);
                check_eq("reset_flags", {rsp_id, rsp_of, rsp_cout}, 0);
            end
            if (rst) begin
                m_wait = 0;
                m_done = 0;
                m_last = 1;
                m_fresh = 1;
                exp_q.delete();
            end else if (m_done) begin
                if (rsp_ready) begin
                    m_done = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_done = 1;
            end else if (e_g0 || e_g1) begin
                exp_q.push_back(ref_result(e_g1, ra[e_g1], rb[e_g1], rm[e_g1]));
                m_wait = NIB;
                m_last = e_g1;
                m_fresh = 0;
            end
        end
    end

    // driver tasks
    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic load_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        ra[r] = a;
        rb[r] = b;
        rm[r] = m;
        rv[r] = 1'b1;
    endtask

    task automatic wait_accept(input int r);
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (r == 0) ? req0_ready : req1_ready;
        end
        check_eq("accept_seen", ok, 1);
    endtask

    task automatic wait_rsp_valid();
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        check_eq("rsp_valid_seen", ok, 1);
    endtask

    task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        load_req(r, a, b, m);
        wait_accept(r);
        @(posedge clk); #1;
        rv[r] = 1'b0;
        wait_rsp_valid();
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        bit acc[2];
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ra[r] = '0; rb[r] = '0; rm[r] = 1'b0; rv[r] = 1'b0;
        end
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);

        // corner arithmetic
        run_op(0, 16'h0001, 16'hFFFF, 1'b0);
        run_op(1, 16'h7FFF, 16'h0001, 1'b0);
        run_op(1, 16'h8000, 16'h0001, 1'b1);
        run_op(1, 16'h0005, 16'h0007, 1'b1);

        // both requesters held valid from reset alternate grants
        rst = 1'b1;
        load_req(0, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
        load_req(1, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
        idle_cycles(1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g = -1;
            for (int i = 0; i < 50 && g < 0; i++) begin
                @(negedge clk);
                if (req0_ready) g = 0;
                else if (req1_ready) g = 1;
            end
            check_eq("grant_order", g, k % 2);
            @(posedge clk); #1;
            if (k < 3 && g >= 0) load_req(g, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
            else begin
                rv[0] = 1'b0;
                rv[1] = 1'b0;
            end
        end
        idle_cycles(10);

        // consumer stalls three DONE cycles
        rsp_ready = 1'b0;
        load_req(0, 16'h1234, 16'h0FED, 1'b1);
        wait_accept(0);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        wait_rsp_valid();
        idle_cycles(3);
        rsp_ready = 1'b1;
        idle_cycles(3);

        // reset during the second CALC cycle aborts the operation
        load_req(0, 16'hAAAA, 16'h5555, 1'b0);
        wait_accept(0);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        idle_cycles(1);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(2);
        run_op(0, 16'h00FF, 16'h0F01, 1'b0);

        // randomized traffic with stalls and rare resets
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rv[r] && $urandom_range(0, 3) == 0)
                    load_req(r, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            acc[0] = req0_ready;
            acc[1] = req1_ready;
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) if (acc[r]) rv[r] = 1'b0;
        end
        rst = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rsp_ready = 1'b1;
        idle_cycles(20);
        mon_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_arb_ctrl.md
ADDSUB_ARB_CTRL -- requirements
Module: addsub_arb_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits, legal values multiples of 4 from 4 to 32.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, rst.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-006 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 Port: req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-008 Port: req0_mode  input  1  requester 0 op: 0 = a+b, 1 = a-b.
REQ-009 Ports req1_valid, req1_ready, req1_a, req1_b, req1_mode SHALL mirror REQ-005..REQ-008 for requester 1.
REQ-010 Port: rsp_valid  output  1  result available.
REQ-011 Port: rsp_ready  input  1  consumer takes result.
REQ-012 Port: rsp_id  output  1  requester index that owns the result.
REQ-013 Port: rsp_sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 Port: rsp_cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-015 Port: rsp_of  output  1  signed two's-complement overflow.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, CALC, DONE.
REQ-018 IDLE: with no valid request, remain IDLE; both ready outputs low.
REQ-019 IDLE arbitration: round-robin; single valid requester wins; both valid -> winner is the requester not granted last; last-grant pointer resets to requester 1, so requester 0 wins first after reset.
REQ-020 Exactly one reqN_ready SHALL be high, combinationally, in an IDLE cycle with any valid request; ready is low in CALC and DONE.
REQ-021 On acceptance: capture a, b XOR {WIDTH{mode}}, carry = mode, id; update last-grant pointer; go to CALC with nibble index 0.
REQ-022 CALC: one 4-bit ripple slice per cycle, nibble index i = 0..WIDTH/4-1 LSB first; sum nibble i = a[i] + b'[i] + carry; carry register updated each cycle.
REQ-023 On the final nibble: rsp_cout = carry out of bit WIDTH-1; rsp_of = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1; go to DONE.
REQ-024 Latency: request accepted in cycle T -> rsp_valid high in cycle T+WIDTH/4+1 (T+5 for WIDTH=16).
REQ-025 DONE: rsp_valid high; rsp_sum, rsp_cout, rsp_of, rsp_id held stable until rsp_ready sampled high.
REQ-026 DONE with rsp_ready high: next state IDLE, rsp_valid low next cycle; new request accepted no earlier than that IDLE cycle.
REQ-027 Request inputs SHALL be ignored outside IDLE; a requester held valid is served later without loss.
REQ-028 rsp_valid SHALL be low in IDLE and CALC.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, nibble index 0, carry 0, last-grant = 1, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_of 0, rsp_id 0, busy 0, both ready 0.
REQ-030 rst in CALC or DONE SHALL abort the operation; no response for it is ever produced.

Verification
REQ-031 req0 add 0x0001+0xFFFF, rsp_ready=1 -> rsp_valid 5 cycles after accept, sum 0x0000, cout 1, of 0, id 0.
REQ-032 req1 add 0x7FFF+0x0001 -> sum 0x8000, cout 0, of 1; sub 0x8000-0x0001 -> sum 0x7FFF, cout 1, of 1; sub 0x0005-0x0007 -> sum 0xFFFE, cout 0, of 0.
REQ-033 Both requesters held valid from reset for 4 operations -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; each result matches its operands.
REQ-034 rsp_ready low 3 cycles in DONE -> rsp_valid and all result outputs unchanged; no ready asserted; IDLE the cycle after rsp_ready rises.
REQ-035 rst pulsed during 2nd CALC cycle -> next cycle all outputs at reset values, no rsp_valid for aborted op; next req0 accepted and completes correctly.
